// File: rtl/acumulador_adc.sv
// Saturating accumulator for 4-bit ADC samples with a sequential BCD converter.
// An event at edge E updates the total at E+1; the BCD digits and listoAcum follow at E+12.
// One pending sample is held while the block is busy; any further event is dropped and flagged.
module acumulador_adc #(
    parameter int ANCHO_DATO = 4,
    parameter int ANCHO_ACUM = 10,
    parameter int LIMITE     = 999
) (
    input  logic                  clk100MHz,
    input  logic                  reset,
    input  logic                  listoControl,
    input  logic [ANCHO_DATO-1:0] Resultado,
    input  logic                  limpiar,
    output logic [ANCHO_ACUM-1:0] Acumulado,
    output logic [3:0]            Unidades,
    output logic [3:0]            Decenas,
    output logic [3:0]            Centenas,
    output logic                  listoAcum,
    output logic                  saturado,
    output logic                  sobrecarga,
    output logic                  ocupado
);

    typedef enum logic [1:0] {
        ESPERA,
        SUMA,
        CONVIERTE,
        PUBLICA
    } estado_t;

    localparam int ANCHO_SUMA = ANCHO_ACUM + 1;
    localparam int ANCHO_SR   = 12 + ANCHO_ACUM;
    localparam int ANCHO_CNT  = $clog2(ANCHO_ACUM + 1);

    localparam logic [ANCHO_SUMA-1:0] LIM_SUMA = ANCHO_SUMA'(LIMITE);
    localparam logic [ANCHO_ACUM-1:0] LIM_ACUM = ANCHO_ACUM'(LIMITE);
    localparam logic [ANCHO_CNT-1:0]  ULTIMA   = ANCHO_CNT'(ANCHO_ACUM - 1);

    estado_t estado;
    estado_t estado_sig;

    logic                  lc_q;
    logic                  evento;
    logic [ANCHO_DATO-1:0] dato;
    logic [ANCHO_DATO-1:0] dato_pend;
    logic                  pend;
    logic [ANCHO_SR-1:0]   sr;
    logic [ANCHO_SR-1:0]   sr_aj;
    logic [ANCHO_SR-1:0]   sr_sig;
    logic [ANCHO_CNT-1:0]  cnt;
    logic [ANCHO_SUMA-1:0] suma;
    logic                  excede;

    assign evento  = listoControl & ~lc_q;
    assign ocupado = (estado != ESPERA);

    // The sum is one bit wider than the total so the limit test sees the true value.
    assign suma   = {1'b0, Acumulado} + ANCHO_SUMA'(dato);
    assign excede = (suma > LIM_SUMA);

    // One double-dabble step: correct each BCD nibble, then shift the whole register.
    always_comb begin
        sr_aj = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr[ANCHO_ACUM + 4*i +: 4] >= 4'd5) begin
                sr_aj[ANCHO_ACUM + 4*i +: 4] = sr[ANCHO_ACUM + 4*i +: 4] + 4'd3;
            end
        end
        sr_sig = {sr_aj[ANCHO_SR-2:0], 1'b0};
    end

    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            estado <= ESPERA;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        unique case (estado)
            ESPERA:    if (evento || pend) estado_sig = SUMA;
            SUMA:      estado_sig = CONVIERTE;
            CONVIERTE: if (cnt == ULTIMA) estado_sig = PUBLICA;
            PUBLICA:   estado_sig = ESPERA;
            default:   estado_sig = ESPERA;
        endcase
        if (limpiar) begin
            estado_sig = ESPERA;
        end
    end

    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            lc_q       <= 1'b0;
            dato       <= '0;
            dato_pend  <= '0;
            pend       <= 1'b0;
            sr         <= '0;
            cnt        <= '0;
            Acumulado  <= '0;
            Unidades   <= 4'd0;
            Decenas    <= 4'd0;
            Centenas   <= 4'd0;
            listoAcum  <= 1'b0;
            saturado   <= 1'b0;
            sobrecarga <= 1'b0;
        end else begin
            lc_q      <= listoControl;
            listoAcum <= 1'b0;
            if (limpiar) begin
                pend       <= 1'b0;
                Acumulado  <= '0;
                Unidades   <= 4'd0;
                Decenas    <= 4'd0;
                Centenas   <= 4'd0;
                saturado   <= 1'b0;
                sobrecarga <= 1'b0;
            end else begin
                unique case (estado)
                    ESPERA: begin
                        // A waiting sample goes first; a simultaneous new event refills the slot.
                        if (pend) begin
                            dato <= dato_pend;
                            pend <= evento;
                            if (evento) dato_pend <= Resultado;
                        end else if (evento) begin
                            dato <= Resultado;
                        end
                    end
                    SUMA: begin
                        if (excede) begin
                            Acumulado <= LIM_ACUM;
                            saturado  <= 1'b1;
                            sr        <= {12'd0, LIM_ACUM};
                        end else begin
                            Acumulado <= suma[ANCHO_ACUM-1:0];
                            sr        <= {12'd0, suma[ANCHO_ACUM-1:0]};
                        end
                        cnt <= '0;
                    end
                    CONVIERTE: begin
                        sr  <= sr_sig;
                        cnt <= cnt + ANCHO_CNT'(1);
                    end
                    PUBLICA: begin
                        Centenas  <= sr[ANCHO_SR-1 -: 4];
                        Decenas   <= sr[ANCHO_SR-5 -: 4];
                        Unidades  <= sr[ANCHO_SR-9 -: 4];
                        listoAcum <= 1'b1;
                    end
                    default: ;
                endcase

                if (ocupado && evento) begin
                    if (pend) begin
                        sobrecarga <= 1'b1;
                    end else begin
                        pend      <= 1'b1;
                        dato_pend <= Resultado;
                    end
                end
            end
        end
    end

endmodule
